// File: rtl/vram_write_arbiter.sv
// ============================================================================
// Module   : vram_write_arbiter
// Brief    : Shares the VRAM write port between a brush client and a fill engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_write_arbiter #(
  parameter int X_W       = 8,
  parameter int DATA_W    = 12,
  parameter int FILL_LAST = 65535
) (
  input  logic                mclk,
  input  logic                rst_n,
  input  logic                draw_req,
  input  logic [X_W-1:0]      draw_x,
  input  logic [X_W-1:0]      draw_y,
  input  logic [DATA_W-1:0]   draw_color,
  input  logic                draw_size,
  output logic                draw_ack,
  input  logic                fill_start,
  input  logic [DATA_W-1:0]   fill_color,
  output logic                fill_done,
  output logic                busy,
  output logic [2*X_W-1:0]    paddr,
  output logic [DATA_W-1:0]   pdata,
  output logic                we
);

  localparam int                c_AW        = 2 * X_W;
  localparam logic [c_AW-1:0]   c_FILL_LAST = c_AW'(FILL_LAST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_BRUSH = 2'd2
  } state_t;

  state_t              r_state;
  logic [X_W-1:0]      r_bx;
  logic [X_W-1:0]      r_by;
  logic [1:0]          r_row;
  logic [1:0]          r_col;
  logic                r_pend;
  logic [DATA_W-1:0]   r_pend_color;

  logic [X_W-1:0]      w_src_x;
  logic [X_W-1:0]      w_src_y;
  logic [1:0]          w_off_x;
  logic [1:0]          w_off_y;
  logic [X_W:0]        w_px;
  logic [X_W:0]        w_py;
  logic                w_in;
  logic [c_AW-1:0]     w_paddr;

  // Brush pixel = centre + offset - 1, one bit wider so under/overflow shows
  // up in the top bit instead of wrapping. Offsets are 0 on the accept edge.
  always_comb begin
    w_src_x = (r_state == S_BRUSH) ? r_bx  : draw_x;
    w_src_y = (r_state == S_BRUSH) ? r_by  : draw_y;
    w_off_x = (r_state == S_BRUSH) ? r_col : 2'd0;
    w_off_y = (r_state == S_BRUSH) ? r_row : 2'd0;
    w_px    = {1'b0, w_src_x} + (X_W+1)'(w_off_x) - (X_W+1)'(1);
    w_py    = {1'b0, w_src_y} + (X_W+1)'(w_off_y) - (X_W+1)'(1);
    w_in    = ~w_px[X_W] & ~w_py[X_W];
    w_paddr = {w_py[X_W-1:0], w_px[X_W-1:0]};
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bx         <= '0;
      r_by         <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_pend       <= 1'b0;
      r_pend_color <= '0;
      paddr        <= '0;
      pdata        <= '0;
      we           <= 1'b0;
      draw_ack     <= 1'b0;
      fill_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      draw_ack  <= 1'b0;
      fill_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fill_start || r_pend) begin
            r_state <= S_FILL;
            busy    <= 1'b1;
            paddr   <= '0;
            pdata   <= r_pend ? r_pend_color : fill_color;
            we      <= 1'b1;
            r_pend  <= 1'b0;
          end else if (draw_req && !draw_ack) begin
            draw_ack <= 1'b1;
            r_bx     <= draw_x;
            r_by     <= draw_y;
            pdata    <= draw_color;
            if (draw_size) begin
              r_state <= S_BRUSH;
              busy    <= 1'b1;
              r_row   <= 2'd0;
              r_col   <= 2'd1;
              we      <= w_in;
              if (w_in) paddr <= w_paddr;
            end else begin
              we    <= 1'b1;
              paddr <= {draw_y, draw_x};
            end
          end else begin
            we <= 1'b0;
          end
        end

        S_FILL: begin
          if (paddr == c_FILL_LAST) begin
            we        <= 1'b0;
            busy      <= 1'b0;
            fill_done <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            paddr <= paddr + c_AW'(1);
          end
        end

        S_BRUSH: begin
          // A fill requested mid-brush is remembered and started once idle.
          if (fill_start) begin
            r_pend       <= 1'b1;
            r_pend_color <= fill_color;
          end
          if (r_row == 2'd3) begin
            we      <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            we <= w_in;
            if (w_in) paddr <= w_paddr;
            if (r_col == 2'd2) begin
              r_col <= 2'd0;
              r_row <= r_row + 2'd1;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_write_arbiter.sv
// ============================================================================
// Module   : tb_vram_write_arbiter
// Brief    : Directed and random checks of vram_write_arbiter against a
//            schedule-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vram_write_arbiter;

  localparam int c_FL = 15;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        draw_req = 1'b0;
  logic [7:0]  draw_x = '0;
  logic [7:0]  draw_y = '0;
  logic [11:0] draw_color = '0;
  logic        draw_size = 1'b0;
  logic        draw_ack;
  logic        fill_start = 1'b0;
  logic [11:0] fill_color = '0;
  logic        fill_done;
  logic        busy;
  logic [15:0] paddr;
  logic [11:0] pdata;
  logic        we;

  vram_write_arbiter #(.X_W(8), .DATA_W(12), .FILL_LAST(c_FL)) dut (
    .mclk(mclk), .rst_n(rst_n), .draw_req(draw_req), .draw_x(draw_x),
    .draw_y(draw_y), .draw_color(draw_color), .draw_size(draw_size),
    .draw_ack(draw_ack), .fill_start(fill_start), .fill_color(fill_color),
    .fill_done(fill_done), .busy(busy), .paddr(paddr), .pdata(pdata), .we(we)
  );

  always #5 mclk = ~mclk;

  // Reference model: on each accept the whole sequence of output cycles is
  // computed up front from the brush/fill rules and replayed one per edge.
  localparam logic [1:0] K_IDLE = 2'd0, K_FILL = 2'd1, K_BRUSH = 2'd2;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [11:0] data;
    logic        ack;
    logic        done;
    logic        busy;
    logic [1:0]  kind;
  } ent_t;

  ent_t        cur = '0;
  ent_t        sched[$];
  logic        pend = 1'b0;
  logic [11:0] pcol = '0;

  int ntests = 0;
  int nfail  = 0;
  logic [15:0] wlog[$];
  logic [11:0] dlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_fill(input logic [11:0] c);
    ent_t e;
    for (int i = 0; i <= c_FL; i++) begin
      e = '0; e.we = 1'b1; e.addr = 16'(i); e.data = c; e.busy = 1'b1; e.kind = K_FILL;
      sched.push_back(e);
    end
    e = '0; e.addr = 16'(c_FL); e.data = c; e.done = 1'b1; e.kind = K_IDLE;
    sched.push_back(e);
  endtask

  task automatic push_brush(input int x, input int y, input logic [11:0] c);
    ent_t e;
    logic [15:0] a;
    int px, py;
    a = cur.addr;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        px = x + dx; py = y + dy;
        e = '0;
        e.we = (px >= 0 && px < 256 && py >= 0 && py < 256);
        if (e.we) a = 16'(py * 256 + px);
        e.addr = a; e.data = c; e.busy = 1'b1; e.kind = K_BRUSH;
        e.ack = (dy == -1 && dx == -1);
        sched.push_back(e);
      end
    end
    e = '0; e.addr = a; e.data = c; e.kind = K_IDLE;
    sched.push_back(e);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      cur = '0; sched.delete(); pend = 1'b0; pcol = '0;
      return;
    end
    if (cur.kind == K_BRUSH && fill_start) begin
      pend = 1'b1; pcol = fill_color;
    end
    if (sched.size() > 0) begin
      cur = sched.pop_front();
    end else if (fill_start || pend) begin
      push_fill(pend ? pcol : fill_color);
      pend = 1'b0;
      cur = sched.pop_front();
    end else if (draw_req && !cur.ack) begin
      if (draw_size) begin
        push_brush(int'(draw_x), int'(draw_y), draw_color);
        cur = sched.pop_front();
      end else begin
        cur = '0; cur.we = 1'b1; cur.addr = {draw_y, draw_x}; cur.data = draw_color;
        cur.ack = 1'b1; cur.kind = K_IDLE;
      end
    end else begin
      cur.we = 1'b0; cur.ack = 1'b0; cur.done = 1'b0; cur.busy = 1'b0; cur.kind = K_IDLE;
    end
  endtask

  task automatic step();
    @(posedge mclk);
    model_edge();
    #1;
    chk("we", 32'(we), 32'(cur.we));
    chk("paddr", 32'(paddr), 32'(cur.addr));
    if (cur.we) chk("pdata", 32'(pdata), 32'(cur.data));
    chk("draw_ack", 32'(draw_ack), 32'(cur.ack));
    chk("fill_done", 32'(fill_done), 32'(cur.done));
    chk("busy", 32'(busy), 32'(cur.busy));
    if (we === 1'b1) begin
      wlog.push_back(paddr);
      dlog.push_back(pdata);
    end
  endtask

  function automatic logic [7:0] rcoord();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 2));
      1:       return 8'($urandom_range(253, 255));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] exp_int[9];
    logic [15:0] exp_cor[4];
    logic        rwe[25];
    logic [15:0] raddr[25];
    logic [11:0] rdata[25];
    int nb, dcyc, acyc, f;

    exp_int = '{16'h1309, 16'h130A, 16'h130B, 16'h1409, 16'h140A,
                16'h140B, 16'h1509, 16'h150A, 16'h150B};
    exp_cor = '{16'h0000, 16'h0001, 16'h0100, 16'h0101};

    // Reset held with both requests active
    rst_n = 1'b0; draw_req = 1'b1; fill_start = 1'b1; fill_color = 12'h0AA;
    draw_x = 8'd5; draw_y = 8'd3; draw_color = 12'hF00; draw_size = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_we", 32'(we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(draw_ack), 0);
      chk("rst_paddr", 32'(paddr), 0);
    end

    // Single pixel, request held across the ack
    rst_n = 1'b1; fill_start = 1'b0;
    step();
    chk("px_we", 32'(we), 1);
    chk("px_paddr", 32'(paddr), 32'h0305);
    chk("px_pdata", 32'(pdata), 32'hF00);
    chk("px_ack", 32'(draw_ack), 1);
    step();
    chk("px_hold_ack", 32'(draw_ack), 0);
    chk("px_hold_we", 32'(we), 0);
    step();
    chk("px_reaccept", 32'(draw_ack), 1);
    draw_req = 1'b0;
    step();

    // 3x3 interior brush
    draw_x = 8'd10; draw_y = 8'd20; draw_color = 12'h0F0; draw_size = 1'b1; draw_req = 1'b1;
    wlog.delete(); dlog.delete(); nb = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (i == 0) draw_req = 1'b0;
      if (busy === 1'b1) nb++;
    end
    chk("int_busy_cycles", 32'(nb), 9);
    chk("int_writes", 32'(wlog.size()), 9);
    if (wlog.size() == 9)
      for (int k = 0; k < 9; k++) chk("int_addr", 32'(wlog[k]), 32'(exp_int[k]));

    // 3x3 corner brush
    draw_x = 8'd0; draw_y = 8'd0; draw_color = 12'h00F; draw_req = 1'b1;
    wlog.delete(); dlog.delete();
    for (int i = 0; i < 11; i++) begin
      step();
      if (i == 0) draw_req = 1'b0;
    end
    chk("cor_writes", 32'(wlog.size()), 4);
    if (wlog.size() == 4)
      for (int k = 0; k < 4; k++) chk("cor_addr", 32'(wlog[k]), 32'(exp_cor[k]));

    // Fill and draw on the same edge: fill first, draw acked after fill_done
    fill_start = 1'b1; fill_color = 12'hABC;
    draw_x = 8'd7; draw_y = 8'd7; draw_color = 12'h123; draw_size = 1'b0; draw_req = 1'b1;
    wlog.delete(); dlog.delete(); dcyc = -1; acyc = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      fill_start = 1'b0;
      if (fill_done === 1'b1) dcyc = i;
      if (draw_ack === 1'b1 && acyc < 0) begin
        acyc = i; draw_req = 1'b0;
      end
    end
    chk("fd_writes", 32'(wlog.size()), 17);
    if (wlog.size() == 17) begin
      for (int k = 0; k < 16; k++) begin
        chk("fd_fill_addr", 32'(wlog[k]), 32'(k));
        chk("fd_fill_data", 32'(dlog[k]), 32'hABC);
      end
      chk("fd_draw_addr", 32'(wlog[16]), 32'h0707);
    end
    chk("fd_done_seen", 32'(dcyc), 16);
    chk("fd_ack_after_done", 32'(acyc), 32'(dcyc + 1));

    // Fill requested mid-brush starts right after the brush completes
    draw_x = 8'd100; draw_y = 8'd100; draw_color = 12'h0F0; draw_size = 1'b1; draw_req = 1'b1;
    step();
    draw_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    fill_start = 1'b1; fill_color = 12'h555;
    step();
    fill_start = 1'b0;
    f = -1;
    for (int i = 0; i < 25; i++) begin
      step();
      rwe[i] = we; raddr[i] = paddr; rdata[i] = pdata;
      if (f < 0 && we === 1'b1 && pdata === 12'h555) f = i;
    end
    chk("mb_fill_found", 32'(f >= 2), 1);
    if (f >= 2) begin
      chk("mb_fill_addr0", 32'(raddr[f]), 0);
      chk("mb_gap_we", 32'(rwe[f-1]), 0);
      chk("mb_last_brush_we", 32'(rwe[f-2]), 1);
      chk("mb_last_brush_addr", 32'(raddr[f-2]), 32'h6565);
    end

    // Reset in the middle of a fill
    fill_start = 1'b1; fill_color = 12'h777;
    step();
    fill_start = 1'b0;
    nb = 0;
    while (paddr !== 16'd7 && nb < 20) begin
      step();
      nb++;
    end
    chk("rf_reached_7", 32'(paddr), 7);
    rst_n = 1'b0;
    step();
    chk("rf_we", 32'(we), 0);
    chk("rf_busy", 32'(busy), 0);
    chk("rf_done", 32'(fill_done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rf_no_done", 32'(fill_done), 0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (draw_req && cur.ack && $urandom_range(0, 1) == 1) draw_req = 1'b0;
      else if (!draw_req && $urandom_range(0, 2) == 0) begin
        draw_req = 1'b1; draw_x = rcoord(); draw_y = rcoord();
        draw_color = 12'($urandom); draw_size = 1'($urandom);
      end
      fill_start = ($urandom_range(0, 39) == 0);
      fill_color = 12'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
